reg_file_mp: RTL
================

# reg_file_mp

Parametrised, multi-write-port register file with same-cycle write-to-read bypass, an optional hardwired zero register and a per-register busy scoreboard. It sits in the decode stage of the CPU pipeline and replaces the single-write-port register file. It serves two combinational read ports (rs/rt) and two write ports: port 0 for the ALU writeback and port 1 for the memory writeback. The scoreboard lets decode detect pending writers without external hazard logic.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes, never busy
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- rs_addr_i  in  ADDR_W  read port A address
- rt_addr_i  in  ADDR_W  read port B address
- rs_data_o  out  DATA_W  read port A data (combinational)
- rt_data_o  out  DATA_W  read port B data (combinational)
- rs_busy_o  out  1  register at rs_addr_i has a pending writer
- rt_busy_o  out  1  register at rt_addr_i has a pending writer
- wr0_en_i  in  1  write port 0 enable
- wr0_addr_i  in  ADDR_W  write port 0 address
- wr0_data_i  in  DATA_W  write port 0 data
- wr1_en_i  in  1  write port 1 enable
- wr1_addr_i  in  ADDR_W  write port 1 address
- wr1_data_i  in  DATA_W  write port 1 data
- sb_set_i  in  1  mark register sb_addr_i busy (producer issued)
- sb_addr_i  in  ADDR_W  scoreboard set address

## Operation
- Storage: DEPTH x DATA_W array plus DEPTH busy bits.
- Reset (rst_n_i low, asynchronous): all registers become 0 and all busy bits become 0, effective immediately. Outputs follow combinationally: data 0, busy 0.
- Write: on a rising edge, if wrN_en_i is set, reg[wrN_addr_i] <= wrN_data_i.
- Both ports enabled to the same address: port 1 wins (the memory result is younger).
- Writes to address 0 when ZERO_REG=1 are dropped.
- Busy clear: any enabled write clears busy[wrN_addr_i] at the same edge.
- Busy set: sb_set_i sets busy[sb_addr_i].
- Set and clear to the same address in the same cycle: set wins, because the new producer supersedes the old one.
- sb_set_i to address 0 with ZERO_REG=1 is ignored.
- Read data: rs_data_o = reg[rs_addr_i] (same for rt).
- With BYPASS=1, a read address matching an enabled write address returns that port's write data this cycle, with port 1 taking priority over port 0.
- With ZERO_REG=1, address 0 always returns 0, overriding the bypass.
- Read busy: rs_busy_o = busy[rs_addr_i].
- With BYPASS=1, busy reads 0 when an enabled write to that address occurs this cycle and no same-address sb_set_i is asserted that cycle.
- Address 0 busy reads 0 when ZERO_REG=1.
- No handshake and no stalls: the block accepts every request in every cycle.

## Timing
- Write latency: 1 edge. Data is visible on the read ports from the following cycle, or in the same cycle via the bypass when BYPASS=1.
- With BYPASS=0, a same-cycle read of a written address returns the old value.
- Read ports are purely combinational from the address, array and write inputs. There is no read-side register.
- Busy: set takes effect from the cycle after sb_set_i. Clear is visible in the write cycle when BYPASS=1, otherwise from the next cycle.
- Reset asserted mid-write: the write is lost and the register stays 0. Reset deasserting on a clock edge: that edge performs no write.
- All state is held when no enable is asserted.

## Test plan
- Reset: hold rst_n_i low, then release.
  - Required: rs_data_o/rt_data_o = 0 and busy = 0 for all 32 addresses.
- Basic write/read: write r5 = 0xDEADBEEF via port 0, read r5 next cycle.
  - Required: 0xDEADBEEF on both read ports.
  - Required: same-cycle read returns 0xDEADBEEF with BYPASS=1 and 0 with BYPASS=0.
- Write conflict: port 0 writes r7 = 0x11 and port 1 writes r7 = 0x22 in the same cycle.
  - Required: bypassed read returns 0x22, and r7 = 0x22 afterwards.
- Zero register: write r0 = 0xFFFFFFFF and assert sb_set_i on r0.
  - Required: r0 reads 0 and rs_busy_o = 0 in that cycle and every later cycle.
- Scoreboard:
  - sb_set_i on r3, then rs_addr_i = 3. Required: rs_busy_o = 1 next cycle.
  - Port 1 writes r3 = 0x55. Required: rs_busy_o = 0 in the write cycle (BYPASS=1) and data reads 0x55.
  - Set and write r3 in the same cycle. Required: busy stays 1.
- Async reset mid-operation: fill r1..r31 with nonzero values, then pulse rst_n_i low between clock edges.
  - Required: all registers read 0 immediately, before the next edge.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: two-read/two-write register file with write-to-read bypass, optional zero register and busy scoreboard
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic              rs_busy_o,
  output logic              rt_busy_o,
  input  logic              wr0_en_i,
  input  logic [ADDR_W-1:0] wr0_addr_i,
  input  logic [DATA_W-1:0] wr0_data_i,
  input  logic              wr1_en_i,
  input  logic [ADDR_W-1:0] wr1_addr_i,
  input  logic [DATA_W-1:0] wr1_data_i,
  input  logic              sb_set_i,
  input  logic [ADDR_W-1:0] sb_addr_i
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  logic wr0_ok;
  logic wr1_ok;

  assign wr0_ok = wr0_en_i && !(ZERO_REG && wr0_addr_i == '0);
  assign wr1_ok = wr1_en_i && !(ZERO_REG && wr1_addr_i == '0);

  // port 1 is applied last so it wins a same-address conflict
  always_comb begin
    regs_d = regs_q;
    if (wr0_ok) regs_d[wr0_addr_i] = wr0_data_i;
    if (wr1_ok) regs_d[wr1_addr_i] = wr1_data_i;
  end

  // set is applied after clear: a newly issued producer supersedes the retiring one
  always_comb begin
    busy_d = busy_q;
    if (wr0_en_i) busy_d[wr0_addr_i] = 1'b0;
    if (wr1_en_i) busy_d[wr1_addr_i] = 1'b0;
    if (sb_set_i) busy_d[sb_addr_i] = 1'b1;
    if (ZERO_REG) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  function automatic logic [DATA_W-1:0] rd_data(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = regs_q[a];
    if (BYPASS && wr0_en_i && wr0_addr_i == a) v = wr0_data_i;
    if (BYPASS && wr1_en_i && wr1_addr_i == a) v = wr1_data_i;
    if (ZERO_REG && a == '0) v = '0;
    return v;
  endfunction

  function automatic logic rd_busy(input logic [ADDR_W-1:0] a);
    logic b;
    logic wr_hit;
    wr_hit = (wr0_en_i && wr0_addr_i == a) || (wr1_en_i && wr1_addr_i == a);
    b = busy_q[a];
    if (BYPASS && wr_hit && !(sb_set_i && sb_addr_i == a)) b = 1'b0;
    if (ZERO_REG && a == '0) b = 1'b0;
    return b;
  endfunction

  assign rs_data_o = rd_data(rs_addr_i);
  assign rt_data_o = rd_data(rt_addr_i);
  assign rs_busy_o = rd_busy(rs_addr_i);
  assign rt_busy_o = rd_busy(rt_addr_i);
endmodule
